// File: rtl/anim_state_ctrl.sv
// anim_state_ctrl: per-player frame-timed animation sequencer producing the sprite state code
module anim_state_ctrl #(
  parameter int FACING = 0,
  parameter int STARTUP_FRAMES = 4,
  parameter int ACTIVE_FRAMES = 2,
  parameter int RECOVERY_FRAMES = 6,
  parameter int DIR_STARTUP_FRAMES = 6,
  parameter int DIR_ACTIVE_FRAMES = 3,
  parameter int DIR_RECOVERY_FRAMES = 8,
  parameter int HITSTUN_FRAMES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       btn_dir_attack,
  input  logic       btn_block,
  input  logic       hit_in,
  output logic [3:0] player_state,
  output logic       hitbox_active,
  output logic       busy,
  output logic       hit_taken,
  output logic       hit_blocked
);
  function automatic logic [7:0] ld(input int n);
    return n <= 1 ? 8'd0 : 8'(n - 1);
  endfunction
  localparam logic [7:0] LD_ST = ld(STARTUP_FRAMES);
  localparam logic [7:0] LD_AC = ld(ACTIVE_FRAMES);
  localparam logic [7:0] LD_RC = ld(RECOVERY_FRAMES);
  localparam logic [7:0] LD_DST = ld(DIR_STARTUP_FRAMES);
  localparam logic [7:0] LD_DAC = ld(DIR_ACTIVE_FRAMES);
  localparam logic [7:0] LD_DRC = ld(DIR_RECOVERY_FRAMES);
  localparam logic [7:0] LD_HIT = ld(HITSTUN_FRAMES);
  logic [3:0] state, next_state, dec_state, seq_state;
  logic [7:0] cnt, next_cnt, dec_cnt, seq_cnt;
  logic       hit_pending, hit, timed, fwd, back, take, blk;
  assign player_state = state;
  assign hit = hit_pending | hit_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= 4'd0;
      cnt         <= 8'd0;
      hit_pending <= 1'b0;
      hit_taken   <= 1'b0;
      hit_blocked <= 1'b0;
    end else if (frame_tick) begin
      state       <= next_state;
      cnt         <= next_cnt;
      hit_pending <= 1'b0;
      hit_taken   <= take;
      hit_blocked <= blk;
    end else begin
      hit_pending <= hit_pending | hit_in;
      hit_taken   <= 1'b0;
      hit_blocked <= 1'b0;
    end
  end
  always_comb begin
    fwd        = FACING != 0 ? btn_left : btn_right;
    back       = FACING != 0 ? btn_right : btn_left;
    dec_state  = btn_attack ? 4'd3 : btn_dir_attack ? 4'd6 : btn_block ? 4'd10 :
                 (fwd & ~back) ? 4'd1 : (back & ~fwd) ? 4'd2 : 4'd0;
    dec_cnt    = btn_attack ? LD_ST : btn_dir_attack ? LD_DST : 8'd0;
    seq_state  = state == 4'd3 ? 4'd4 : state == 4'd4 ? 4'd5 :
                 state == 4'd6 ? 4'd7 : state == 4'd7 ? 4'd8 : dec_state;
    seq_cnt    = state == 4'd3 ? LD_AC : state == 4'd4 ? LD_RC :
                 state == 4'd6 ? LD_DAC : state == 4'd7 ? LD_DRC : dec_cnt;
    timed      = state >= 4'd3 && state <= 4'd9;
    next_state = (hit && state != 4'd10) ? 4'd9 : hit ? 4'd10 :
                 (timed && cnt != 8'd0) ? state : timed ? seq_state : dec_state;
    next_cnt   = (hit && state != 4'd10) ? LD_HIT : hit ? cnt :
                 (timed && cnt != 8'd0) ? cnt - 8'd1 : timed ? seq_cnt : dec_cnt;
  end
  always_comb begin
    hitbox_active = state == 4'd4 || state == 4'd7;
    busy          = state >= 4'd3 && state <= 4'd9;
    take          = hit && state != 4'd10;
    blk           = hit && state == 4'd10;
  end
endmodule

// File: doc/anim_state_ctrl.md
Name: anim_state_ctrl

Overview:
- Per-player animation/action sequencer that produces the 4-bit player state code consumed by the sprite ROM pixel mux.
- Converts held buttons and hit events into timed attack, hit-stun and block sequences.
- State advances once per video frame via frame_tick.
- Two instances are used: player 1 with FACING=0, player 2 with FACING=1.

Parameters:
- FACING, 0, 0: btn_right is forward. 1: btn_left is forward.
- STARTUP_FRAMES, 4, frames spent in attack start (code 3).
- ACTIVE_FRAMES, 2, frames spent in attack end (code 4).
- RECOVERY_FRAMES, 6, frames spent in attack pull (code 5).
- DIR_STARTUP_FRAMES, 6, frames spent in directional attack start (code 6).
- DIR_ACTIVE_FRAMES, 3, frames spent in directional attack end (code 7).
- DIR_RECOVERY_FRAMES, 8, frames spent in directional attack pull (code 8).
- HITSTUN_FRAMES, 10, frames spent in got hit (code 9).
- All frame parameters are 8-bit, legal range 1..255. A value of 0 behaves as 1.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-clk pulse per video frame
- btn_left  in  1  level
- btn_right  in  1  level
- btn_attack  in  1  level
- btn_dir_attack  in  1  level
- btn_block  in  1  level
- hit_in  in  1  one-clk pulse: opponent hitbox overlapped this player
- player_state  out  4  state code to sprite ROM mux: 0 idle, 1 walk, 2 walkback, 3 attackstart, 4 attackend, 5 attackpull, 6 dirattstart, 7 dirattend, 8 dirattpull, 9 gothit, 10 block
- hitbox_active  out  1  high while player_state is 4 or 7
- busy  out  1  high in codes 3–9, i.e. input is ignored
- hit_taken  out  1  one-clk pulse on entry to gothit
- hit_blocked  out  1  one-clk pulse when a hit is absorbed in block

Behaviour:
- Reset: player_state=0, frame counter=0, hit_pending=0, and all outputs 0.
  - Reset mid-sequence aborts immediately to idle.
  - rst has priority over everything else.
- Hit capture: hit_pending sets on any clk with hit_in=1.
  - It is cleared on the clk where frame_tick=1, when it is consumed.
  - If hit_in and frame_tick coincide, the hit is consumed on that same tick.
- Timing: state, counter, hit_taken and hit_blocked update only on clk edges with frame_tick=1. Otherwise everything holds and pulses are 0.
- Outputs are registered. hitbox_active and busy are decoded from the registered state with zero added latency.
- On a tick, evaluate in priority order:
  1. hit_pending and state≠10: go to 9 and load counter=HITSTUN_FRAMES-1; pulse hit_taken.
     - This applies from any state, including mid-attack and gothit itself (re-hit restarts stun).
  2. hit_pending and state=10: stay in 10 and pulse hit_blocked.
  3. Timed states (3–9), counter≠0: decrement the counter.
  4. Timed states, counter=0:
     - 3→4 (load ACTIVE-1)
     - 4→5 (load RECOVERY-1)
     - 5→free decode
     - 6→7, 7→8, 8→free decode (DIR_* equivalents)
     - 9→free decode
- Free decode is used from 0/1/2/10 and on exit from sequences. Inputs are sampled on the tick.
  - btn_attack → 3 (load STARTUP-1)
  - else btn_dir_attack → 6 (load DIR_STARTUP-1)
  - else btn_block → 10
  - else forward only → 1; back only → 2
  - else (none, or left+right together) → 0
- Dwell: each timed state is displayed for exactly N frame ticks, where N is its parameter.
  - A full basic attack therefore lasts STARTUP+ACTIVE+RECOVERY ticks before the next decode.
- Attack buttons are level-sensitive. Holding btn_attack chains a new attack directly from attackpull exit with no idle frame.
- Counter is 8-bit and never underflows; a decrement occurs only when it is ≠0.

Test Plan:
- rst held for 3 clks mid-attack (state 4) → next clk state 0, hitbox_active=0, busy=0, no pulses.
- Default params, btn_attack held for 1 tick then released → states 3×4 ticks, 4×2 ticks (hitbox_active=1), 5×6 ticks, then 0. busy=1 for exactly 12 ticks.
- FACING=1, btn_left held → state 1. btn_right held → state 2. Both held → 0. Repeat with FACING=0 and confirm the mapping is swapped.
- hit_in pulse 100 clks before a tick while in state 3 → on the tick state 9 with hit_taken=1 for one clk. Second hit_in after 4 ticks → stun restarts, 10 further ticks in 9.
- btn_block held, hit_in pulsed → state stays 10, hit_blocked=1 for one clk, hit_taken stays 0.
- hit_in on the same clk as frame_tick while idle → state 9 on that edge. No second hit is taken on the following tick.
